// File: rtl/tx_word_serializer_if.sv
// rtl/tx_word_serializer_if.sv - tx FIFO read side and byte stream bundle for tx_word_serializer
interface tx_word_serializer_if #(
  parameter int DATA_WIDTH = 128
);
  // tx FIFO read side (first-word fall-through)
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_enable;

  // byte stream toward the transmit line logic
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic                  tx_last;

  // serializer side
  modport master (
    input  fifo_empty,
    input  read_data,
    output read_enable,
    output tx_valid,
    input  tx_ready,
    output tx_data,
    output tx_last
  );

  // FIFO / line side
  modport slave (
    output fifo_empty,
    output read_data,
    input  read_enable,
    input  tx_valid,
    output tx_ready,
    input  tx_data,
    input  tx_last
  );
endinterface

// File: rtl/tx_word_serializer.sv
// rtl/tx_word_serializer.sv - pops tx FIFO words and streams them out one byte per transfer
module tx_word_serializer #(
  parameter int DATA_WIDTH = 128,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  tx_word_serializer_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] words_sent
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int BC_WIDTH  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BC_WIDTH-1:0] LAST_IDX = BC_WIDTH'(NUM_BYTES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BC_WIDTH-1:0]   r_byte_cnt;
  logic [CNT_WIDTH-1:0]  r_words_sent;

  logic                  w_send;
  logic                  w_xfer;
  logic                  w_last_xfer;
  logic                  w_load;
  logic [7:0]            w_head_byte;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // The outgoing byte always sits at one fixed end of the shift register,
  // so the byte mux is a constant slice and each transfer is an 8-bit shift.
  assign w_head_byte = MSB_FIRST ? r_shift[DATA_WIDTH-1 -: 8] : r_shift[7:0];
  assign w_shift_nxt = MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: stay in SEND across words when the FIFO can refill on the last byte
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_load) w_state_nxt = S_SEND;
      S_SEND: if (w_last_xfer && !w_load) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: handshake decode and the combinational pop strobe.
  // read_enable is held low during reset so a queued word is never popped
  // while the serializer cannot capture it.
  always_comb begin
    w_send          = (r_state == S_SEND);
    w_xfer          = w_send && bus.tx_ready;
    w_last_xfer     = w_xfer && (r_byte_cnt == LAST_IDX);
    w_load          = n_rst && !bus.fifo_empty && (!w_send || w_last_xfer);
    bus.read_enable = w_load;
    bus.tx_valid    = w_send;
    bus.tx_data     = w_send ? w_head_byte : 8'h00;
    bus.tx_last     = w_send && (r_byte_cnt == LAST_IDX);
    busy            = w_send;
  end

  // Datapath: load on pop, shift on every non-final transfer, hold on stall
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (w_load) begin
      r_shift    <= bus.read_data;
      r_byte_cnt <= '0;
    end else if (w_xfer) begin
      r_shift    <= w_shift_nxt;
      r_byte_cnt <= r_byte_cnt + BC_WIDTH'(1);
    end
  end

  // Completed-word counter; wraps naturally at its width
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_words_sent <= '0;
    end else if (w_last_xfer) begin
      r_words_sent <= r_words_sent + CNT_WIDTH'(1);
    end
  end

  assign words_sent = r_words_sent;

endmodule

// File: tb/tb_tx_word_serializer.sv
// tb/tb_tx_word_serializer.sv - self-checking bench for tx_word_serializer (MSB and LSB instances)
`timescale 1ns/1ps
module tb_tx_word_serializer;

  localparam int DW = 128;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  tx_word_serializer_if #(.DATA_WIDTH(DW)) bus0 ();
  tx_word_serializer_if #(.DATA_WIDTH(DW)) bus1 ();

  logic        busy0, busy1;
  logic [15:0] ws0;
  logic [3:0]  ws1;

  tx_word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) u_msb (
    .clk(clk), .n_rst(n_rst), .bus(bus0), .busy(busy0), .words_sent(ws0)
  );
  tx_word_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0), .CNT_WIDTH(4)) u_lsb (
    .clk(clk), .n_rst(n_rst), .bus(bus1), .busy(busy1), .words_sent(ws1)
  );

  // bench-driven inputs
  logic [1:0]         fifo_empty;
  logic [1:0][DW-1:0] read_data;
  logic [1:0]         tx_ready;
  assign bus0.fifo_empty = fifo_empty[0];
  assign bus0.read_data  = read_data[0];
  assign bus0.tx_ready   = tx_ready[0];
  assign bus1.fifo_empty = fifo_empty[1];
  assign bus1.read_data  = read_data[1];
  assign bus1.tx_ready   = tx_ready[1];

  // observed outputs
  logic [1:0]       re_o, valid_o, last_o, busy_o;
  logic [1:0][7:0]  data_o;
  logic [1:0][15:0] ws_o;
  assign re_o    = {bus1.read_enable, bus0.read_enable};
  assign valid_o = {bus1.tx_valid, bus0.tx_valid};
  assign last_o  = {bus1.tx_last, bus0.tx_last};
  assign busy_o  = {busy1, busy0};
  assign data_o  = {bus1.tx_data, bus0.tx_data};
  assign ws_o    = {{12'h000, ws1}, ws0};

  // FIFO contents and reference model: bytes popped but not yet sent ({last, data})
  logic [DW-1:0] fifo_q[2][$];
  logic [8:0]    exp_q[2][$];
  int unsigned   exp_ws[2];
  int            n_valid[2];
  int            n_re[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ws_mask(input int k);
    return (k == 0) ? 32'h0000_FFFF : 32'h0000_000F;
  endfunction

  // i-th byte on the wire for a word: MSB-first walks down from the top byte
  function automatic logic [7:0] byte_of(input logic [DW-1:0] w, input int i, input bit msb);
    int pos;
    pos = msb ? (NB - 1 - i) : i;
    return w[pos*8 +: 8];
  endfunction

  task automatic refresh_fifo();
    for (int k = 0; k < 2; k++) begin
      fifo_empty[k] = (fifo_q[k].size() == 0);
      read_data[k]  = (fifo_q[k].size() != 0) ? fifo_q[k][0] : '0;
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] w);
    fifo_q[k].push_back(w);
    refresh_fifo();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      n_valid[k] = 0;
      n_re[k]    = 0;
    end
  endtask

  // One clock: called at a negedge with inputs set; checks, then applies the edge to the model
  task automatic step();
    logic          exp_v, exp_re, lst;
    logic [1:0]    xfer, pop;
    logic [DW-1:0] w;
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_v  = n_rst && (exp_q[k].size() != 0);
      exp_re = n_rst && (fifo_q[k].size() != 0) &&
               ((exp_q[k].size() == 0) || (exp_q[k].size() == 1 && tx_ready[k]));
      chk($sformatf("k%0d read_enable", k), {31'd0, re_o[k]}, {31'd0, exp_re});
      chk($sformatf("k%0d tx_valid", k), {31'd0, valid_o[k]}, {31'd0, exp_v});
      chk($sformatf("k%0d busy", k), {31'd0, busy_o[k]}, {31'd0, exp_v});
      chk($sformatf("k%0d words_sent", k), {16'd0, ws_o[k]}, exp_ws[k]);
      if (exp_v) begin
        chk($sformatf("k%0d tx_data", k), {24'd0, data_o[k]}, {24'd0, exp_q[k][0][7:0]});
        chk($sformatf("k%0d tx_last", k), {31'd0, last_o[k]}, {31'd0, exp_q[k][0][8]});
      end
      xfer[k] = exp_v && tx_ready[k];
      pop[k]  = exp_re;
      if (valid_o[k] === 1'b1) n_valid[k]++;
      if (re_o[k] === 1'b1) n_re[k]++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (xfer[k]) begin
        if (exp_q[k][0][8]) exp_ws[k] = (exp_ws[k] + 1) & ws_mask(k);
        void'(exp_q[k].pop_front());
      end
      if (pop[k]) begin
        w = fifo_q[k].pop_front();
        for (int i = 0; i < NB; i++) begin
          lst = (i == NB - 1);
          exp_q[k].push_back({lst, byte_of(w, i, k == 0)});
        end
      end
    end
    refresh_fifo();
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles, output int steps);
    steps = 0;
    while (((fifo_q[0].size() != 0) || (fifo_q[1].size() != 0) ||
            (exp_q[0].size() != 0) || (exp_q[1].size() != 0)) && steps < max_cycles) begin
      step();
      steps++;
    end
    chk("drain_bound", {31'd0, steps < max_cycles}, 32'd1);
  endtask

  initial begin
    int            steps;
    int            stalls[2];
    int            idx;
    logic [DW-1:0] w;

    n_rst     = 1'b1;
    tx_ready  = '0;
    exp_ws[0] = 0;
    exp_ws[1] = 0;
    refresh_fifo();
    clear_counts();

    // asynchronous reset mid-clock: outputs clear without waiting for an edge
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst k%0d read_enable", k), {31'd0, re_o[k]}, 32'd0);
      chk($sformatf("rst k%0d tx_valid", k), {31'd0, valid_o[k]}, 32'd0);
      chk($sformatf("rst k%0d tx_data", k), {24'd0, data_o[k]}, 32'd0);
      chk($sformatf("rst k%0d tx_last", k), {31'd0, last_o[k]}, 32'd0);
      chk($sformatf("rst k%0d busy", k), {31'd0, busy_o[k]}, 32'd0);
      chk($sformatf("rst k%0d words_sent", k), {16'd0, ws_o[k]}, 32'd0);
    end
    @(negedge clk);
    step();
    step();
    n_rst = 1'b1;
    repeat (5) step();

    // single word, tx_ready held high
    push(0, 128'h000102030405060708090A0B0C0D0E0F);
    push(1, 128'h0F0E0D0C0B0A09080706050403020100);
    tx_ready = '1;
    clear_counts();
    drain(100, steps);
    chk("single_cycles", steps, 32'd17);
    chk("single_pops_msb", n_re[0], 32'd1);
    chk("single_pops_lsb", n_re[1], 32'd1);
    chk("single_valid_msb", n_valid[0], 32'd16);
    chk("single_ws_msb", {16'd0, ws_o[0]}, 32'd1);
    chk("single_ws_lsb", {16'd0, ws_o[1]}, 32'd1);
    step();

    // backpressure: 4 stall cycles on byte 3 and on byte 10
    push(0, 128'h000102030405060708090A0B0C0D0E0F);
    push(1, 128'h0F0E0D0C0B0A09080706050403020100);
    stalls[0] = 0;
    stalls[1] = 0;
    clear_counts();
    for (int c = 0; c < 100; c++) begin
      if ((fifo_q[0].size() == 0) && (fifo_q[1].size() == 0) &&
          (exp_q[0].size() == 0) && (exp_q[1].size() == 0)) break;
      for (int k = 0; k < 2; k++) begin
        idx = NB - exp_q[k].size();
        if ((exp_q[k].size() != 0) &&
            ((idx == 3 && stalls[k] < 4) || (idx == 10 && stalls[k] < 8))) begin
          tx_ready[k] = 1'b0;
          stalls[k]++;
        end else begin
          tx_ready[k] = 1'b1;
        end
      end
      step();
    end
    tx_ready = '1;
    chk("bp_valid_cycles_msb", n_valid[0], 32'd24);
    chk("bp_valid_cycles_lsb", n_valid[1], 32'd24);
    chk("bp_ws_msb", {16'd0, ws_o[0]}, 32'd2);

    // back-to-back: words 1..17, no bubble between words
    for (int v = 1; v <= 17; v++) begin
      w = DW'(v);
      push(0, w);
      push(1, w);
    end
    clear_counts();
    drain(400, steps);
    chk("b2b_cycles", steps, 32'd273);
    chk("b2b_valid_msb", n_valid[0], 32'd272);
    chk("b2b_valid_lsb", n_valid[1], 32'd272);
    chk("b2b_pops_msb", n_re[0], 32'd17);
    chk("b2b_ws_msb", {16'd0, ws_o[0]}, 32'd19);
    chk("b2b_ws_lsb_wrap", {16'd0, ws_o[1]}, 32'd3);

    // random words and random backpressure
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (fifo_q[k].size() < 3 && $urandom_range(0, 3) == 0)
          push(k, {$urandom, $urandom, $urandom, $urandom});
        tx_ready[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    tx_ready = '1;
    drain(300, steps);

    // reset while byte 7 of a word is on the line, second word queued
    for (int k = 0; k < 2; k++) begin
      push(k, {$urandom, $urandom, $urandom, $urandom});
      push(k, {$urandom, $urandom, $urandom, $urandom});
    end
    steps = 0;
    while (exp_q[0].size() != 9 && steps < 40) begin
      step();
      steps++;
    end
    chk("midrst_reach_byte7", {31'd0, steps < 40}, 32'd1);
    chk("midrst_byte7_on_line", {24'd0, data_o[0]}, {24'd0, exp_q[0][0][7:0]});
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'd0, valid_o[0]}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o[0]}, 32'd0);
    chk("midrst_read_enable", {31'd0, re_o[0]}, 32'd0);
    chk("midrst_ws", {16'd0, ws_o[0]}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      exp_ws[k] = 0;
    end
    @(negedge clk);
    step();
    n_rst = 1'b1;
    clear_counts();
    drain(100, steps);
    chk("midrst_second_word_bytes", n_valid[0], 32'd16);
    chk("midrst_ws_after", {16'd0, ws_o[0]}, 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_word_serializer.md
Name: tx_word_serializer

Overview:
- Read-side consumer of the 128-bit tx FIFO.
- Pops one 128-bit word at a time and emits it as 16 bytes on a byte-wide valid/ready stream toward the transmit line logic.
- Supports back-to-back words with no idle cycle between them.
- Runs in the 200 MHz core clock domain.

Parameters:
- DATA_WIDTH, 128, FIFO word width; must be a multiple of 8.
- MSB_FIRST, 1, 1 = byte [DATA_WIDTH-1:DATA_WIDTH-8] sent first; 0 = byte [7:0] sent first.
- CNT_WIDTH, 16, width of the words_sent counter.

Ports:
- clk  in  1  core clock, rising-edge.
- n_rst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  tx FIFO empty flag.
- read_data  in  DATA_WIDTH  tx FIFO head word; first-word fall-through, valid whenever fifo_empty=0.
- read_enable  out  1  pop strobe; the head word is removed at the clk edge where read_enable=1.
- tx_valid  out  1  tx_data holds a valid byte.
- tx_ready  in  1  downstream accepts the byte this cycle.
- tx_data  out  8  current byte.
- tx_last  out  1  current byte is the final byte (index 15) of its word.
- busy  out  1  a word is in flight (state SEND).
- words_sent  out  CNT_WIDTH  count of fully transmitted words; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, shift register=0, byte_cnt=0, words_sent=0.
  - tx_valid=0, tx_data=0, tx_last=0, busy=0, read_enable=0.
- Handshake: a byte transfers on a clk edge where tx_valid=1 and tx_ready=1.
- State IDLE:
  - tx_valid=0.
  - read_enable = !fifo_empty, combinational.
  - If read_enable=1: capture read_data into the shift register at the edge, set byte_cnt=0, go to SEND.
- State SEND:
  - tx_valid=1; tx_data = the selected byte of the shift register.
  - tx_last = (byte_cnt==15); busy=1.
  - While tx_ready=0, tx_data, tx_last and the shift register hold stable.
  - On transfer with byte_cnt<15: shift by 8 bits toward the output byte and increment byte_cnt.
  - On transfer with byte_cnt==15:
    - words_sent increments; 0xFFFF wraps to 0x0000.
    - If fifo_empty=0: read_enable=1 in that same cycle, combinational. The shift register reloads from read_data, byte_cnt becomes 0, and the state stays SEND, with no bubble.
    - Otherwise go to IDLE.
- read_enable is never asserted when fifo_empty=1, and never asserted in SEND except on the last-byte transfer cycle.
- Latency:
  - From fifo_empty falling while in IDLE, tx_valid rises 1 cycle later.
  - Sustained throughput is 1 byte/cycle with tx_ready held high, i.e. 16 cycles per word.
- Reset mid-word: the partially sent word is discarded (it has already been popped). Nothing is re-read.
- Width rules: byte_cnt is 4 bits; the shift amount is a fixed 8 bits.

Test Plan:
- Reset: assert n_rst=0 mid-clock -> all outputs 0 immediately; after release with fifo_empty=1 for 5 cycles -> read_enable=0, tx_valid=0.
- Single word: FIFO holds 128'h000102030405060708090A0B0C0D0E0F, tx_ready=1, MSB_FIRST=1 -> read_enable pulses 1 cycle; bytes 00..0F on 16 consecutive cycles; tx_last only on 0F; words_sent=1; returns to IDLE.
- Backpressure: same word, tx_ready low on byte indices 3 and 10 for 4 cycles each -> tx_data stays 03 and 0A while stalled; no byte dropped or duplicated; 24 cycles total.
- Back-to-back: FIFO holds words with values 1..17 -> read_enable pulses exactly on each tx_last transfer; 272 consecutive valid cycles; words_sent=17; low bytes arrive in order 01..11h (hex, i.e. 1..17 decimal).
- LSB order: MSB_FIRST=0, word 128'h0F0E...0100 -> bytes 00..0F.
- Reset during byte 7 of a word, with a second word queued -> tx_valid=0 at once; after release the second word is sent intact; words_sent counts from 0.
